// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I R-type definitions: opcode, ALUOp codes,
//               funct3/funct7 fields, encoder FSM state type and the
//               R-type encode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } rtype_enc_t;

  // Builds the R-type word; legal=0 for ALUOp values with no mapping.
  function automatic rtype_enc_t encode_rtype(input logic [3:0] alu,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs1,
                                              input logic [4:0] rs2);
    rtype_enc_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    f3      = FUNCT3_ADD_SUB;
    f7      = FUNCT7_BASE;
    r.legal = 1'b1;
    case (alu)
      ALU_ADD: f3 = FUNCT3_ADD_SUB;
      ALU_SUB: f7 = FUNCT7_SUB;
      ALU_AND: f3 = FUNCT3_AND;
      ALU_OR:  f3 = FUNCT3_OR;
      ALU_XOR: f3 = FUNCT3_XOR;
      ALU_SLT: f3 = FUNCT3_SLT;
      default: r.legal = 1'b0;
    endcase
    r.word = {f7, rs2, rs1, f3, rd, OPCODE_RTYPE};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtype_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rtype_instr_encoder_if
// Description : Bus bundle for the R-type encoder: command handshake
//               (op_*), restart, instruction-memory write port (imem_*)
//               and status outputs.
//               master : command source / memory side
//               slave  : the encoder
// Revision    : 1.0 - initial release
// ============================================================================
interface rtype_instr_encoder_if #(
  parameter int IMEM_AW = 8
);
  logic               op_valid;
  logic               op_ready;
  logic [3:0]         op_alu;
  logic [4:0]         op_rd;
  logic [4:0]         op_rs1;
  logic [4:0]         op_rs2;
  logic               restart;
  logic               imem_we;
  logic               imem_ready;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [IMEM_AW:0]   instr_count;
  logic               illegal_op;
  logic               mem_full;
  logic               busy;

  modport master (
    output op_valid, op_alu, op_rd, op_rs1, op_rs2, restart, imem_ready,
    input  op_ready, imem_we, imem_addr, imem_wdata, instr_count,
           illegal_op, mem_full, busy
  );

  modport slave (
    input  op_valid, op_alu, op_rd, op_rs1, op_rs2, restart, imem_ready,
    output op_ready, imem_we, imem_addr, imem_wdata, instr_count,
           illegal_op, mem_full, busy
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, synchronous active-low reset.
//   clk, rst_n            clock / reset
//   push, push_data       write side (ignored when full)
//   pop, pop_data         read side, pop_data is the head (ignored when empty)
//   full, empty, count    occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
endmodule
`default_nettype wire

// File: rtl/rtype_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rtype_instr_encoder
// Description : Encodes (ALUOp, rd, rs1, rs2) commands into RV32I R-type
//               words, buffers them and writes them to consecutive
//               instruction-memory addresses.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of rtype_instr_encoder_if (command handshake,
//                restart, imem write port, instr_count/illegal_op/
//                mem_full/busy status)
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_instr_encoder
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_AW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rtype_instr_encoder_if.slave bus
);
  localparam int                 CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IMEM_AW-1:0] ADDR_LAST = '1;
  localparam logic [IMEM_AW:0]   CAPACITY  = {1'b1, {IMEM_AW{1'b0}}};

  enc_state_t       state;
  enc_state_t       state_next;
  rtype_enc_t       enc;
  logic             ready_en;
  logic             op_ready_int;
  logic             mem_full_int;
  logic             accept;
  logic             push;
  logic             pop;
  logic             we_int;
  logic             busy_int;
  logic             restart_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_head;
  logic [IMEM_AW-1:0] addr;
  logic [IMEM_AW:0] written;
  logic [IMEM_AW:0] reserved;
  logic             illegal_q;

  assign enc          = encode_rtype(bus.op_alu, bus.op_rd, bus.op_rs1, bus.op_rs2);
  // Reservations cover queued + written words, so the memory can never
  // be oversubscribed even while writes are stalled.
  assign mem_full_int = (reserved == CAPACITY);
  assign op_ready_int = ready_en && !fifo_full && !mem_full_int;
  assign accept       = bus.op_valid && op_ready_int;
  assign push         = accept && enc.legal;
  assign we_int       = (state == ST_WRITE) && !fifo_empty;
  assign pop          = we_int && bus.imem_ready;
  assign busy_int     = !fifo_empty || we_int;
  assign restart_ok   = bus.restart && !busy_int;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (enc.word),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_WRITE;
      ST_WRITE: begin
        if (pop) begin
          if (addr == ADDR_LAST)
            state_next = ST_FULL;
          else if (fifo_count == CNT_W'(1) && !push)
            state_next = ST_IDLE;
        end
      end
      ST_FULL:  if (restart_ok) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      addr      <= '0;
      written   <= '0;
      reserved  <= '0;
      illegal_q <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      illegal_q <= accept && !enc.legal;
      if (restart_ok) begin
        addr    <= '0;
        written <= '0;
      end else if (pop) begin
        written <= written + (IMEM_AW+1)'(1);
        // Saturate on the last word instead of wrapping to 0.
        if (addr != ADDR_LAST) addr <= addr + IMEM_AW'(1);
      end
      // A command accepted alongside an honoured restart is the first
      // reservation of the new program.
      reserved <= (restart_ok ? '0 : reserved) + (IMEM_AW+1)'(push);
    end
  end

  assign bus.op_ready    = op_ready_int;
  assign bus.imem_we     = we_int;
  assign bus.imem_addr   = addr;
  assign bus.imem_wdata  = we_int ? fifo_head : 32'h0;
  assign bus.instr_count = written;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_full    = mem_full_int;
  assign bus.busy        = busy_int;
endmodule
`default_nettype wire

// File: tb/tb_rtype_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rtype_instr_encoder
// Description : Self-checking bench for rtype_instr_encoder. A main DUT
//               (IMEM_AW=8) covers encoding, back-pressure, illegal ops,
//               restart and reset; a small DUT (IMEM_AW=2) covers memory
//               exhaustion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int AW_S  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtype_instr_encoder_if #(.IMEM_AW(AW))   b8 ();
  rtype_instr_encoder_if #(.IMEM_AW(AW_S)) bs ();

  rtype_instr_encoder #(.FIFO_DEPTH(DEPTH), .IMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  rtype_instr_encoder #(.FIFO_DEPTH(DEPTH), .IMEM_AW(AW_S)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bs));

  int checks = 0;
  int errors = 0;

  bit ready_force = 1'b1;
  bit rand_rdy    = 1'b0;
  bit rnd_bit     = 1'b0;
  assign b8.imem_ready = rand_rdy ? rnd_bit : ready_force;
  assign bs.imem_ready = 1'b1;

  always begin
    @(posedge clk);
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Observation: completed writes, illegal pulses, handshake stability.
  logic [AW-1:0]   obs_addr [$];
  logic [31:0]     obs_data [$];
  logic [AW_S-1:0] sobs_addr [$];
  int              ill_cnt   = 0;
  int              stab_viol = 0;
  bit              prev_stall = 1'b0;
  logic [AW-1:0]   prev_addr;
  logic [31:0]     prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (b8.imem_we !== 1'b1 || b8.imem_addr !== prev_addr ||
                         b8.imem_wdata !== prev_data))
        stab_viol++;
      prev_stall = b8.imem_we && !b8.imem_ready;
      prev_addr  = b8.imem_addr;
      prev_data  = b8.imem_wdata;
      if (b8.imem_we && b8.imem_ready) begin
        obs_addr.push_back(b8.imem_addr);
        obs_data.push_back(b8.imem_wdata);
      end
      if (b8.illegal_op) ill_cnt++;
      if (bs.imem_we) sobs_addr.push_back(bs.imem_addr);
    end
  end

  // Reference encoding from the field table: funct3 per ALUOp, funct7
  // bit 30 only for SUB, opcode 51 (0110011).
  function automatic void ref_encode(input int alu, input int rd, input int rs1,
                                     input int rs2, output bit legal,
                                     output logic [31:0] word);
    int f3_of [6] = '{0, 0, 7, 6, 4, 2};
    legal = (alu >= 0 && alu < 6);
    word  = 32'h0;
    if (legal)
      word = 32'((alu == 1 ? (1 << 30) : 0) + rs2 * (1 << 20) + rs1 * (1 << 15) +
                 f3_of[alu] * (1 << 12) + rd * (1 << 7) + 51);
  endfunction

  task automatic do_reset();
    b8.op_valid = 1'b0; b8.restart = 1'b0;
    bs.op_valid = 1'b0; bs.restart = 1'b0;
    rand_rdy = 1'b0; ready_force = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_addr.delete(); obs_data.delete(); sobs_addr.delete();
  endtask

  task automatic send(input int alu, input int rd, input int rs1, input int rs2);
    int n = 0;
    b8.op_alu = 4'(alu); b8.op_rd = 5'(rd); b8.op_rs1 = 5'(rs1); b8.op_rs2 = 5'(rs2);
    b8.op_valid = 1'b1;
    while (!b8.op_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (b8.op_ready) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: op_ready=%0b expected 1 within 200 cycles", b8.op_ready);
    end
    b8.op_valid = 1'b0;
  endtask

  task automatic drain8(input string tag);
    int n = 0;
    while (b8.busy && n < 2000) begin @(posedge clk); #1; n++; end
    checks++;
    if (b8.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: busy=%0b expected 0", tag, b8.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.op_valid = 1'b0; b8.restart = 1'b0; bs.op_valid = 1'b0; bs.restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b8.op_ready, b8.imem_we, b8.illegal_op, b8.mem_full, b8.busy} !== 5'b0 ||
        b8.imem_addr !== '0 || b8.imem_wdata !== 32'h0 || b8.instr_count !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b we=%0b ill=%0b full=%0b busy=%0b addr=%0h wd=%0h cnt=%0d expected all 0",
               b8.op_ready, b8.imem_we, b8.illegal_op, b8.mem_full, b8.busy,
               b8.imem_addr, b8.imem_wdata, b8.instr_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b8.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: op_ready=%0b expected 1", b8.op_ready);
    end
  endtask

  task automatic test_add();
    do_reset();
    send(0, 3, 1, 2);
    drain8("add");
    checks++;
    if (obs_data.size() != 1 || obs_addr[0] !== 8'd0 || obs_data[0] !== 32'h002081B3) begin
      errors++;
      $display("FAIL add_write: n=%0d addr=%0h data=%0h expected 1 write @0 data 002081b3",
               obs_data.size(), obs_addr.size() ? obs_addr[0] : 8'hxx,
               obs_data.size() ? obs_data[0] : 32'hx);
    end
    checks++;
    if (b8.instr_count !== 9'd1) begin
      errors++;
      $display("FAIL add_count: instr_count=%0d expected 1", b8.instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    bit          lg;
    do_reset();
    send(1, 5, 6, 7);
    send(2, 1, 2, 3);
    send(5, 4, 5, 6);
    drain8("b2b");
    checks++;
    if (obs_data.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d expected 3", obs_data.size());
    end else begin
      checks++;
      if (obs_data[0] !== 32'h407302B3 || obs_addr[0] !== 8'd0) begin
        errors++;
        $display("FAIL b2b_sub: data=%0h addr=%0h expected 407302b3 @0", obs_data[0], obs_addr[0]);
      end
      checks++;
      if (obs_data[1] !== 32'h003170B3 || obs_addr[1] !== 8'd1) begin
        errors++;
        $display("FAIL b2b_and: data=%0h addr=%0h expected 003170b3 @1", obs_data[1], obs_addr[1]);
      end
      ref_encode(5, 4, 5, 6, lg, exp_w);
      checks++;
      if (obs_data[2] !== exp_w || obs_data[2][14:12] !== 3'b010 || obs_addr[2] !== 8'd2) begin
        errors++;
        $display("FAIL b2b_slt: data=%0h addr=%0h expected %0h (funct3 010) @2",
                 obs_data[2], obs_addr[2], exp_w);
      end
    end
  endtask

  task automatic test_illegal();
    int ill0;
    logic [31:0] exp_w;
    bit lg;
    do_reset();
    ill0 = ill_cnt;
    send(15, 9, 9, 9);
    checks++;
    if (b8.illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: illegal_op=%0b expected 1", b8.illegal_op);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ill_cnt - ill0 != 1 || b8.imem_addr !== 8'd0 || obs_data.size() != 0 || b8.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_effect: pulses=%0d addr=%0h writes=%0d busy=%0b expected 1,0,0,0",
               ill_cnt - ill0, b8.imem_addr, obs_data.size(), b8.busy);
    end
    send(0, 1, 2, 3);
    drain8("illegal_next");
    ref_encode(0, 1, 2, 3, lg, exp_w);
    checks++;
    if (obs_data.size() != 1 || obs_addr[0] !== 8'd0 || obs_data[0] !== exp_w) begin
      errors++;
      $display("FAIL illegal_next_write: writes=%0d expected 1 write @0 data %0h", obs_data.size(), exp_w);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    logic [31:0] w;
    bit lg;
    int a, d, s, t;
    do_reset();
    ready_force = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 5); d = $urandom_range(0, 31);
      s = $urandom_range(0, 31); t = $urandom_range(0, 31);
      ref_encode(a, d, s, t, lg, w);
      exp_q.push_back(w);
      if (i == 4) ready_force = 1'b1;
      send(a, d, s, t);
      if (i == 3) begin
        checks++;
        if (b8.op_ready !== 1'b0 || b8.imem_we !== 1'b1 || b8.imem_addr !== 8'd0 ||
            b8.imem_wdata !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_full: rdy=%0b we=%0b addr=%0h wd=%0h expected 0,1,0,%0h",
                   b8.op_ready, b8.imem_we, b8.imem_addr, b8.imem_wdata, exp_q[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b8.op_ready !== 1'b0 || b8.imem_wdata !== exp_q[0] || b8.imem_addr !== 8'd0) begin
          errors++;
          $display("FAIL bp_stable: rdy=%0b addr=%0h wd=%0h expected 0,0,%0h",
                   b8.op_ready, b8.imem_addr, b8.imem_wdata, exp_q[0]);
        end
      end
    end
    drain8("bp");
    checks++;
    if (obs_data.size() != 6) begin
      errors++;
      $display("FAIL bp_count: writes=%0d expected 6", obs_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_data[i] !== exp_q[i] || obs_addr[i] !== 8'(i)) begin
          errors++;
          $display("FAIL bp_order[%0d]: data=%0h addr=%0h expected %0h @%0h",
                   i, obs_data[i], obs_addr[i], exp_q[i], i);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q [$];
    logic [31:0] w;
    bit lg;
    int a, n_ill, ill0, sv0, bad;
    do_reset();
    rand_rdy = 1'b1;
    n_ill = 0; ill0 = ill_cnt; sv0 = stab_viol; bad = 0;
    for (int i = 0; i < 50; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
      ref_encode(a, i % 32, (i * 7) % 32, $urandom_range(0, 31), lg, w);
      send(a, i % 32, (i * 7) % 32, int'(w[24:20]));
      if (lg) exp_q.push_back(w);
      else n_ill++;
    end
    drain8("rand");
    rand_rdy = 1'b0;
    checks++;
    if (obs_data.size() != exp_q.size() || b8.instr_count !== 9'(exp_q.size())) begin
      errors++;
      $display("FAIL rand_count: writes=%0d instr_count=%0d expected %0d",
               obs_data.size(), b8.instr_count, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (obs_data[i] !== exp_q[i] || obs_addr[i] !== 8'(i)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_stream: %0d words wrong expected 0", bad);
      end
    end
    checks++;
    if (ill_cnt - ill0 != n_ill || stab_viol != sv0) begin
      errors++;
      $display("FAIL rand_illegal_stable: pulses=%0d expected %0d, stability violations=%0d expected 0",
               ill_cnt - ill0, n_ill, stab_viol - sv0);
    end
  endtask

  task automatic test_restart();
    do_reset();
    ready_force = 1'b0;
    send(0, 1, 2, 3);
    repeat (2) @(posedge clk);
    #1;
    b8.restart = 1'b1;
    @(posedge clk);
    #1;
    b8.restart = 1'b0;
    ready_force = 1'b1;
    drain8("rs_busy");
    checks++;
    if (b8.instr_count !== 9'd1 || b8.imem_addr !== 8'd1) begin
      errors++;
      $display("FAIL restart_ignored: count=%0d addr=%0h expected 1,1", b8.instr_count, b8.imem_addr);
    end
    b8.restart = 1'b1;
    @(posedge clk);
    #1;
    b8.restart = 1'b0;
    checks++;
    if (b8.instr_count !== 9'd0 || b8.imem_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_idle: count=%0d addr=%0h expected 0,0", b8.instr_count, b8.imem_addr);
    end
    send(4, 2, 2, 2);
    drain8("rs_pre");
    obs_addr.delete(); obs_data.delete();
    b8.restart = 1'b1;
    send(3, 6, 7, 8);
    b8.restart = 1'b0;
    drain8("rs_same");
    checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 8'd0 || b8.instr_count !== 9'd1) begin
      errors++;
      $display("FAIL restart_same_cycle: writes=%0d count=%0d expected 1 write @0, count 1",
               obs_addr.size(), b8.instr_count);
    end
  endtask

  task automatic test_mem_full();
    int acc = 0;
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bs.op_alu = 4'($urandom_range(0, 5));
      bs.op_rd = 5'($urandom); bs.op_rs1 = 5'($urandom); bs.op_rs2 = 5'($urandom);
      bs.op_valid = 1'b1;
      n = 0;
      while (!bs.op_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (bs.op_ready) begin @(posedge clk); #1; acc++; end
      bs.op_valid = 1'b0;
    end
    n = 0;
    while (bs.busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (acc != 4 || bs.instr_count !== 3'd4 || bs.mem_full !== 1'b1 || bs.op_ready !== 1'b0 ||
        bs.busy !== 1'b0) begin
      errors++;
      $display("FAIL memfull_state: acc=%0d count=%0d full=%0b rdy=%0b busy=%0b expected 4,4,1,0,0",
               acc, bs.instr_count, bs.mem_full, bs.op_ready, bs.busy);
    end
    checks++;
    if (sobs_addr.size() != 4 || sobs_addr[0] !== 2'd0 || sobs_addr[3] !== 2'd3 || bs.imem_addr !== 2'd3) begin
      errors++;
      $display("FAIL memfull_addrs: writes=%0d final addr=%0h expected 4 writes 0..3, addr held at 3",
               sobs_addr.size(), bs.imem_addr);
    end
    bs.restart = 1'b1;
    @(posedge clk);
    #1;
    bs.restart = 1'b0;
    checks++;
    if (bs.imem_addr !== 2'd0 || bs.instr_count !== 3'd0 || bs.mem_full !== 1'b0 || bs.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL memfull_restart: addr=%0h count=%0d full=%0b rdy=%0b expected 0,0,0,1",
               bs.imem_addr, bs.instr_count, bs.mem_full, bs.op_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_w;
    bit lg;
    do_reset();
    ready_force = 1'b0;
    send(0, 1, 1, 1);
    send(1, 2, 2, 2);
    send(2, 3, 3, 3);
    checks++;
    if (b8.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: busy=%0b expected 1", b8.busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (b8.imem_we !== 1'b0 || b8.busy !== 1'b0 || b8.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: we=%0b busy=%0b rdy=%0b expected 0,0,0",
               b8.imem_we, b8.busy, b8.op_ready);
    end
    rst_n = 1'b1;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    obs_addr.delete(); obs_data.delete();
    repeat (3) @(posedge clk);
    #1;
    send(0, 3, 1, 2);
    drain8("midrst");
    ref_encode(0, 3, 1, 2, lg, exp_w);
    checks++;
    if (obs_data.size() != 1 || obs_addr[0] !== 8'd0 || obs_data[0] !== exp_w) begin
      errors++;
      $display("FAIL midrst_next: writes=%0d expected exactly 1 write @0 data %0h", obs_data.size(), exp_w);
    end
  endtask

  initial begin
    b8.op_valid = 1'b0; b8.op_alu = '0; b8.op_rd = '0; b8.op_rs1 = '0; b8.op_rs2 = '0;
    b8.restart = 1'b0;
    bs.op_valid = 1'b0; bs.op_alu = '0; bs.op_rd = '0; bs.op_rs1 = '0; bs.op_rs2 = '0;
    bs.restart = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_random();
    test_restart();
    test_mem_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
